// File: rtl/sa_out_requant_streamer.sv
// rtl/sa_out_requant_streamer.sv - capture SA result matrix, requantize, stream one row per cycle
// Optional ReLU on the requantized output: define SA_OUT_RELU_EN.
module sa_out_requant_streamer #(
    parameter int D_W  = 8,
    parameter int SA_R = 16,
    parameter int SA_C = 16
) (
    input  logic                                     I_CLK,
    input  logic                                     I_RST,
    input  logic                                     I_OUT_VLD,
    input  logic [0:SA_R-1][0:SA_C-1][D_W-1:0]       I_OUT_MATRIX,
    input  logic [D_W-1:0]                           I_SCALE,
    input  logic [3:0]                               I_SHIFT,
    input  logic                                     I_ROW_RDY,
    output logic                                     O_ROW_VLD,
    output logic [0:SA_C-1][D_W-1:0]                 O_ROW_DATA,
    output logic [$clog2(SA_R)-1:0]                  O_ROW_IDX,
    output logic                                     O_ROW_LAST,
    output logic                                     O_BUSY,
    output logic                                     O_OVERFLOW
);

    localparam int IDX_W = $clog2(SA_R);
    // Product headroom also covers the largest rounding term (1<<14) for narrow D_W.
    localparam int PW = (2 * D_W + 2 > 18) ? 2 * D_W + 2 : 18;
    localparam logic signed [PW-1:0] Q_MAX = PW'((1 << (D_W - 1)) - 1);
    localparam logic signed [PW-1:0] Q_MIN = ~Q_MAX;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SA_R - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                             state_q, state_d;
    logic [IDX_W-1:0]                   cnt_q, cnt_d;
    logic [0:SA_R-1][0:SA_C-1][D_W-1:0] mat_q, mat_d;
    logic [D_W-1:0]                     scale_q, scale_d;
    logic [3:0]                         shift_q, shift_d;
    logic                               vld_q, vld_d;
    logic [0:SA_C-1][D_W-1:0]           data_q, data_d;
    logic [IDX_W-1:0]                   idx_q, idx_d;
    logic                               last_q, last_d;
    logic                               ovf_q, ovf_d;

    logic [0:SA_C-1][D_W-1:0]           row_rq;
    logic                               hs;
    logic                               final_hs;

    function automatic logic [D_W-1:0] requant(
        input logic [D_W-1:0] x,
        input logic [D_W-1:0] s,
        input logic [3:0]     sh
    );
        logic signed [PW-1:0] p;
        logic signed [PW-1:0] q;
        logic [D_W-1:0]       res;
        p = $signed({{(PW - D_W){x[D_W-1]}}, x}) * $signed({{(PW - D_W){1'b0}}, s});
        if (sh != 4'd0) begin
            p = p + (PW'(1) << (sh - 4'd1));
        end
        q = p >>> sh;
        if (q > Q_MAX) begin
            res = Q_MAX[D_W-1:0];
        end else if (q < Q_MIN) begin
            res = Q_MIN[D_W-1:0];
        end else begin
            res = q[D_W-1:0];
        end
`ifdef SA_OUT_RELU_EN
        if (res[D_W-1]) begin
            res = '0;
        end
`endif
        return res;
    endfunction

    always_comb begin
        row_rq = '0;
        for (int c = 0; c < SA_C; c++) begin
            row_rq[c] = requant(mat_q[cnt_q][c], scale_q, shift_q);
        end
    end

    assign hs       = vld_q & I_ROW_RDY;
    assign final_hs = hs & last_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mat_d   = mat_q;
        scale_d = scale_q;
        shift_d = shift_q;
        vld_d   = vld_q;
        data_d  = data_q;
        idx_d   = idx_q;
        last_d  = last_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (I_OUT_VLD) begin
                    mat_d   = I_OUT_MATRIX;
                    scale_d = I_SCALE;
                    shift_d = I_SHIFT;
                    cnt_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (final_hs) begin
                    vld_d = 1'b0;
                    // A new matrix arriving exactly as the old one drains is taken, not dropped.
                    if (I_OUT_VLD) begin
                        mat_d   = I_OUT_MATRIX;
                        scale_d = I_SCALE;
                        shift_d = I_SHIFT;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (I_OUT_VLD) begin
                        ovf_d = 1'b1;
                    end
                    // cnt_q names the next row to load; the last row stays put until accepted.
                    if (!vld_q || hs) begin
                        vld_d  = 1'b1;
                        data_d = row_rq;
                        idx_d  = cnt_q;
                        last_d = (cnt_q == LAST_IDX);
                        cnt_d  = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mat_q   <= '0;
            scale_q <= '0;
            shift_q <= '0;
            vld_q   <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mat_q   <= mat_d;
            scale_q <= scale_d;
            shift_q <= shift_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
        end
    end

    assign O_ROW_VLD  = vld_q;
    assign O_ROW_DATA = data_q;
    assign O_ROW_IDX  = idx_q;
    assign O_ROW_LAST = last_q;
    assign O_BUSY     = (state_q == STREAM);
    assign O_OVERFLOW = ovf_q;

endmodule

// File: tb/tb_sa_out_requant_streamer.sv
// tb/tb_sa_out_requant_streamer.sv - directed self-checking bench for sa_out_requant_streamer
module tb_sa_out_requant_streamer;

    localparam int D_W  = 8;
    localparam int SA_R = 16;
    localparam int SA_C = 16;

    logic                                 clk = 1'b0;
    logic                                 rst;
    logic                                 out_vld;
    logic [0:SA_R-1][0:SA_C-1][D_W-1:0]   mat;
    logic [D_W-1:0]                       scale;
    logic [3:0]                           shift;
    logic                                 row_rdy;
    logic                                 row_vld;
    logic [0:SA_C-1][D_W-1:0]             row_data;
    logic [$clog2(SA_R)-1:0]              row_idx;
    logic                                 row_last;
    logic                                 busy;
    logic                                 overflow;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sa_out_requant_streamer #(.D_W(D_W), .SA_R(SA_R), .SA_C(SA_C)) dut (
        .I_CLK        (clk),
        .I_RST        (rst),
        .I_OUT_VLD    (out_vld),
        .I_OUT_MATRIX (mat),
        .I_SCALE      (scale),
        .I_SHIFT      (shift),
        .I_ROW_RDY    (row_rdy),
        .O_ROW_VLD    (row_vld),
        .O_ROW_DATA   (row_data),
        .O_ROW_IDX    (row_idx),
        .O_ROW_LAST   (row_last),
        .O_BUSY       (busy),
        .O_OVERFLOW   (overflow)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [D_W-1:0] rl(input logic [D_W-1:0] v);
`ifdef SA_OUT_RELU_EN
        return v[D_W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    task automatic fill_const(input logic [D_W-1:0] v);
        for (int r = 0; r < SA_R; r++)
            for (int c = 0; c < SA_C; c++)
                mat[r][c] = v;
    endtask

    // Ramp values stay small and positive so scale 64 / shift 6 maps them to themselves.
    task automatic fill_ramp;
        for (int r = 0; r < SA_R; r++)
            for (int c = 0; c < SA_C; c++)
                mat[r][c] = 8'(r * 4 + c);
    endtask

    function automatic logic [127:0] const_row(input logic [D_W-1:0] v);
        logic [0:SA_C-1][D_W-1:0] row;
        for (int c = 0; c < SA_C; c++) row[c] = v;
        return row;
    endfunction

    function automatic logic [127:0] ramp_row(input int r);
        logic [0:SA_C-1][D_W-1:0] row;
        for (int c = 0; c < SA_C; c++) row[c] = 8'(r * 4 + c);
        return row;
    endfunction

    task automatic pulse(input logic [D_W-1:0] s, input logic [3:0] sh);
        scale   = s;
        shift   = sh;
        out_vld = 1'b1;
        tick();
        out_vld = 1'b0;
    endtask

    task automatic check_row(input string tag, input int r, input logic [127:0] exp);
        check_eq({tag, "_vld"},  128'(row_vld), 128'(1));
        check_eq({tag, "_idx"},  128'(row_idx), 128'(r));
        check_eq({tag, "_last"}, 128'(row_last), 128'(r == SA_R - 1));
        check_eq({tag, "_data"}, 128'(row_data), exp);
    endtask

    task automatic check_reset_outs(input string tag);
        check_eq({tag, "_vld"},  128'(row_vld), 128'(0));
        check_eq({tag, "_data"}, 128'(row_data), 128'(0));
        check_eq({tag, "_idx"},  128'(row_idx), 128'(0));
        check_eq({tag, "_last"}, 128'(row_last), 128'(0));
        check_eq({tag, "_busy"}, 128'(busy), 128'(0));
        check_eq({tag, "_ovf"},  128'(overflow), 128'(0));
    endtask

    task automatic drain;
        int n;
        n       = 0;
        row_rdy = 1'b1;
        while (busy && n < 60) begin
            tick();
            n++;
        end
        check_eq("drain_idle", 128'(busy), 128'(0));
    endtask

    logic [0:SA_C-1][D_W-1:0] exp_row;

    initial begin
        rst     = 1'b1;
        out_vld = 1'b0;
        mat     = '0;
        scale   = '0;
        shift   = '0;
        row_rdy = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_reset_outs("reset");

        // Basic: all 16, scale 64, shift 6 -> 16 everywhere
        fill_const(8'd16);
        pulse(8'd64, 4'd6);
        check_eq("basic_busy_t1", 128'(busy), 128'(1));
        check_eq("basic_vld_t1",  128'(row_vld), 128'(0));
        tick();
        for (int r = 0; r < SA_R; r++) begin
            check_row("basic", r, const_row(8'd16));
            tick();
        end
        check_eq("basic_vld_end",  128'(row_vld), 128'(0));
        check_eq("basic_busy_end", 128'(busy), 128'(0));
        check_eq("basic_ovf",      128'(overflow), 128'(0));

        // Rounding/saturation: -3,3,127,-128 with scale 255 shift 2
        for (int r = 0; r < SA_R; r++)
            for (int c = 0; c < SA_C; c += 4) begin
                mat[r][c]   = 8'hFD;
                mat[r][c+1] = 8'h03;
                mat[r][c+2] = 8'h7F;
                mat[r][c+3] = 8'h80;
            end
        for (int c = 0; c < SA_C; c += 4) begin
            exp_row[c]   = rl(8'h80);
            exp_row[c+1] = 8'h7F;
            exp_row[c+2] = 8'h7F;
            exp_row[c+3] = rl(8'h80);
        end
        pulse(8'd255, 4'd2);
        tick();
        check_row("sat", 0, exp_row);
        drain();

        // Round half up: 3 -> 2, -3 -> -1 with scale 1 shift 1
        for (int r = 0; r < SA_R; r++)
            for (int c = 0; c < SA_C; c += 2) begin
                mat[r][c]   = 8'h03;
                mat[r][c+1] = 8'hFD;
            end
        for (int c = 0; c < SA_C; c += 2) begin
            exp_row[c]   = 8'h02;
            exp_row[c+1] = rl(8'hFF);
        end
        pulse(8'd1, 4'd1);
        tick();
        check_row("rnd", 0, exp_row);
        drain();

        // Back-pressure on row 3, then back-to-back accept on final handshake
        fill_ramp();
        pulse(8'd64, 4'd6);
        tick();
        for (int r = 0; r < SA_R; r++) begin
            check_row("bp", r, ramp_row(r));
            if (r == 3) begin
                row_rdy = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    tick();
                    check_row("bp_stall", 3, ramp_row(3));
                    check_eq("bp_stall_busy", 128'(busy), 128'(1));
                end
                row_rdy = 1'b1;
            end
            if (r == SA_R - 1) begin
                fill_const(8'd16);
                out_vld = 1'b1;
                tick();
                out_vld = 1'b0;
            end else begin
                tick();
            end
        end
        check_eq("b2b_bubble_vld", 128'(row_vld), 128'(0));
        check_eq("b2b_busy",       128'(busy), 128'(1));
        check_eq("b2b_ovf",        128'(overflow), 128'(0));
        tick();
        check_row("b2b", 0, const_row(8'd16));
        drain();
        check_eq("b2b_ovf_end", 128'(overflow), 128'(0));

        // Pulse during row 7 is dropped; original matrix completes intact
        fill_ramp();
        pulse(8'd64, 4'd6);
        tick();
        for (int r = 0; r < SA_R; r++) begin
            check_row("ovf_stream", r, ramp_row(r));
            if (r == 7) begin
                fill_const(8'h55);
                out_vld = 1'b1;
                tick();
                out_vld = 1'b0;
                check_eq("ovf_set", 128'(overflow), 128'(1));
            end else begin
                tick();
            end
        end
        check_eq("ovf_idle", 128'(busy), 128'(0));
        check_eq("ovf_sticky", 128'(overflow), 128'(1));

        // Reset during row 5 clears everything including overflow
        fill_ramp();
        pulse(8'd64, 4'd6);
        tick();
        for (int r = 0; r < 5; r++) tick();
        check_eq("rst_mid_idx", 128'(row_idx), 128'(5));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outs("rst_mid");
        fill_const(8'd16);
        pulse(8'd64, 4'd6);
        check_eq("rst_after_busy", 128'(busy), 128'(1));
        tick();
        check_row("rst_after", 0, const_row(8'd16));
        drain();

        // ReLU: -5 * 1 >> 0
        fill_const(8'hFB);
        pulse(8'd1, 4'd0);
        tick();
        check_row("relu", 0, const_row(rl(8'hFB)));
        drain();

        // Scale 0 gives all zeros
        fill_ramp();
        pulse(8'd0, 4'd3);
        tick();
        check_row("zero_scale", 0, const_row(8'd0));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
